// File: rtl/lobster_dbus_arbiter.sv
// Purpose: shares one SRAM port among fetch, load and store requesters; one transaction at a time.
// Latency: grant at N, ce high from N+1, ack one cycle after rdy (or timeout), IDLE the cycle after; 4 cycles minimum.
// Backpressure: requesters hold req until their ack; req is only sampled in IDLE, and rdy only in WAIT.
//
// Ports:
//   clk, rst                        clock and synchronous active-high reset
//   fetch_req/addr/ack              instruction fetch requester (always 64-bit read)
//   load_req/addr/size/ack          data load requester
//   store_req/addr/size/data/ack    data store requester
//   rsp_data, err, busy             read data (valid with fetch/load ack), timeout flag, not-idle
//   ce, we, addr, size, data_out    SRAM command, held through WAIT
//   data_in, rdy                    SRAM read data and completion
module lobster_dbus_arbiter #(
    parameter int ADDR_WIDTH     = 36,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int FETCH_STARVE   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_ack,
    input  logic                  load_req,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [1:0]            load_size,
    output logic                  load_ack,
    input  logic                  store_req,
    input  logic [ADDR_WIDTH-1:0] store_addr,
    input  logic [1:0]            store_size,
    input  logic [63:0]           store_data,
    output logic                  store_ack,
    output logic [63:0]           rsp_data,
    output logic                  err,
    output logic                  busy,
    output logic                  ce,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [1:0]            size,
    output logic [63:0]           data_out,
    input  logic [63:0]           data_in,
    input  logic                  rdy
);

    localparam logic [7:0] TCNT_LAST  = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] STARVE_LIM = 4'(FETCH_STARVE);
    localparam logic [3:0] STARVE_MAX = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    typedef enum logic [1:0] {
        OWN_FETCH,
        OWN_LOAD,
        OWN_STORE
    } owner_t;

    state_t     state;
    owner_t     owner;
    logic [7:0] tcnt;
    logic [3:0] starve_cnt;

    logic grant_fetch;
    logic grant_load;
    logic grant_store;
    logic grant_any;

    // Fixed priority store > load > fetch, except a starved fetch jumps the queue.
    always_comb begin
        grant_fetch = 1'b0;
        grant_load  = 1'b0;
        grant_store = 1'b0;
        if (fetch_req && (starve_cnt >= STARVE_LIM)) begin
            grant_fetch = 1'b1;
        end else if (store_req) begin
            grant_store = 1'b1;
        end else if (load_req) begin
            grant_load = 1'b1;
        end else if (fetch_req) begin
            grant_fetch = 1'b1;
        end
        grant_any = grant_fetch | grant_load | grant_store;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            owner      <= OWN_FETCH;
            tcnt       <= '0;
            starve_cnt <= '0;
            fetch_ack  <= 1'b0;
            load_ack   <= 1'b0;
            store_ack  <= 1'b0;
            rsp_data   <= '0;
            err        <= 1'b0;
            busy       <= 1'b0;
            ce         <= 1'b0;
            we         <= 1'b0;
            addr       <= '0;
            size       <= '0;
            data_out   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        state <= S_ISSUE;
                        busy  <= 1'b1;
                        // Command goes out registered, so ce is already high during ISSUE.
                        ce    <= 1'b1;
                        we    <= grant_store;
                        if (grant_fetch) begin
                            owner      <= OWN_FETCH;
                            addr       <= fetch_addr;
                            size       <= 2'b11;
                            starve_cnt <= '0;
                        end else begin
                            if (grant_store) begin
                                owner    <= OWN_STORE;
                                addr     <= store_addr;
                                size     <= store_size;
                                data_out <= store_data;
                            end else begin
                                owner <= OWN_LOAD;
                                addr  <= load_addr;
                                size  <= load_size;
                            end
                            if (fetch_req && (starve_cnt != STARVE_MAX)) begin
                                starve_cnt <= starve_cnt + 4'd1;
                            end
                        end
                    end
                end

                S_ISSUE: begin
                    tcnt  <= '0;
                    state <= S_WAIT;
                end

                S_WAIT: begin
                    // rdy is checked first so a completion on the timeout edge is not an error.
                    if (rdy) begin
                        ce    <= 1'b0;
                        we    <= 1'b0;
                        err   <= 1'b0;
                        state <= S_RESP;
                        if (owner != OWN_STORE) begin
                            rsp_data <= data_in;
                        end
                        fetch_ack <= (owner == OWN_FETCH);
                        load_ack  <= (owner == OWN_LOAD);
                        store_ack <= (owner == OWN_STORE);
                    end else if (tcnt == TCNT_LAST) begin
                        ce        <= 1'b0;
                        we        <= 1'b0;
                        err       <= 1'b1;
                        rsp_data  <= '0;
                        state     <= S_RESP;
                        fetch_ack <= (owner == OWN_FETCH);
                        load_ack  <= (owner == OWN_LOAD);
                        store_ack <= (owner == OWN_STORE);
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end

                S_RESP: begin
                    fetch_ack <= 1'b0;
                    load_ack  <= 1'b0;
                    store_ack <= 1'b0;
                    err       <= 1'b0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/lobster_dbus_arbiter.md
Name: lobster_dbus_arbiter

Overview:
Single-port memory bus arbiter and sequencer for the lobster CPU core. It shares the one SRAM interface (ce/we/addr/data/rdy) between three requesters: instruction fetch, data load and data store. It issues one transaction at a time, holds the command until the SRAM signals ready, then returns data and an ack to the winning requester. Fixed priority with a fetch anti-starvation override and a per-transaction timeout.

Parameters:
ADDR_WIDTH, 36, memory address width in bits
TIMEOUT_CYCLES, 255, max WAIT cycles before the transaction is aborted (1..255, 8-bit counter)
FETCH_STARVE, 4, lost arbitrations after which fetch is promoted to top priority (1..15)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  reset, synchronous, active-high
fetch_req  in  1  fetch request, held until fetch_ack
fetch_addr  in  ADDR_WIDTH  fetch address
fetch_ack  out  1  one-cycle completion pulse to fetch
load_req  in  1  load request, held until load_ack
load_addr  in  ADDR_WIDTH  load address
load_size  in  2  00=8, 01=16, 10=32, 11=64 bit
load_ack  out  1  one-cycle completion pulse to load
store_req  in  1  store request, held until store_ack
store_addr  in  ADDR_WIDTH  store address
store_size  in  2  same encoding as load_size
store_data  in  64  store data, right-aligned
store_ack  out  1  one-cycle completion pulse to store
rsp_data  out  64  read data, valid while fetch_ack or load_ack is high
err  out  1  high with the ack when the transaction timed out
busy  out  1  high in ISSUE/WAIT/RESP
ce  out  1  command enable to SRAM
we  out  1  write enable to SRAM
addr  out  ADDR_WIDTH  SRAM address
size  out  2  access size to SRAM
data_out  out  64  SRAM write data
data_in  in  64  SRAM read data
rdy  in  1  SRAM ready/complete

Behaviour:
- Reset (rst high at posedge, overrides everything): state=IDLE; ce, we, all acks, err, busy = 0; addr, size, data_out, rsp_data = 0; starve and timeout counters = 0. An in-flight transaction is abandoned with no ack.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req is high, select the winner, latch its addr, size and data (store only), and go to ISSUE. If no req is high, stay in IDLE.
- Priority: store > load > fetch. Exception: if starve_cnt >= FETCH_STARVE and fetch_req is high, fetch wins.
- Fetch always uses size=11 and we=0.
- starve_cnt: +1 (saturating) at each IDLE arbitration where fetch_req is high and fetch loses. Cleared when fetch is granted.
- ISSUE (1 cycle): drive ce=1, and we=1 only for a store. Clear tcnt. Go to WAIT.
- WAIT: ce, we, addr, size and data_out are held stable.
  - rdy=1 at posedge: ce<=0, we<=0; for fetch/load, rsp_data<=data_in; go to RESP.
  - Else tcnt+1. If tcnt reaches TIMEOUT_CYCLES-1: ce<=0, we<=0, rsp_data<=0, err flagged; go to RESP.
- RESP (1 cycle): the winner's ack=1. err=1 only if timed out. rsp_data is held. Next state is IDLE.
- Requester handshake:
  - A requester deasserts or changes req in the cycle after its ack.
  - The arbiter never samples req during RESP, so a held req cannot double-issue.
  - A req that drops before being granted is simply not served.
- Latency: request seen in IDLE at cycle N → ce high N+1..; rdy sampled at cycle M → ack in cycle M+1; IDLE at M+2. Minimum 4 cycles per transaction with rdy=1 immediately.
- rdy sampled outside WAIT is ignored.
- Simultaneous rdy and timeout on the same edge: rdy wins, err=0.
- At most one ack is high in any cycle; busy=0 only in IDLE.

Test Plan:
1. Reset, then fetch_req with fetch_addr=0xF800, rdy=1 in the first WAIT cycle, data_in=0x1122334455667788 → ce high 2 cycles, we=0, size=11, fetch_ack at cycle 4 with rsp_data=0x1122334455667788, err=0.
2. store_req, load_req and fetch_req all raised in the same cycle, store_data=0xDEAD, store_size=10, rdy=1 each WAIT → grant order store (we=1, data_out=0xDEAD, size=10), then load, then fetch; exactly one ack per RESP.
3. load_req and store_req kept continuously re-requesting while fetch_req is held → fetch granted at the 5th arbitration (FETCH_STARVE=4); starve_cnt returns to 0.
4. load_req with rdy held low, TIMEOUT_CYCLES=8 → ce drops after 8 WAIT cycles; load_ack=1 with err=1 and rsp_data=0; back in IDLE next cycle.
5. rst asserted during WAIT of a store → next cycle ce=0, we=0, no store_ack, state IDLE; a following fetch completes normally.
6. load granted, rdy=1 on exactly the timeout edge → load_ack with err=0 and rsp_data=data_in.
